// File: rtl/regularization_4bit_sync_pkg.sv
// Shared constants, counter-width helper and output-decision encoding
// for the four-channel debounce-and-lockout filter.
package regularization_4bit_sync_pkg;

  localparam int DEBOUNCE_TIME_DEF = 2;
  localparam int DELAY_DEF         = 500;
  localparam int NUM_CHANNELS      = 4;

  // A counter that must hold 0..maxVal; never narrower than one bit so DELAY=0 still elaborates.
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

  typedef enum logic [1:0] {
    OUT_CLEAR   = 2'd0,
    OUT_RISE    = 2'd1,
    OUT_BLOCKED = 2'd2,
    OUT_HOLD    = 2'd3
  } outAction_e;

endpackage

// File: rtl/regularization_channel.sv
// Single-bit debounce followed by a rising-edge lockout; the output is registered
// and decided from the next-state debounced level.
module regularization_channel
  import regularization_4bit_sync_pkg::*;
#(
  parameter int DEBOUNCE_TIME = DEBOUNCE_TIME_DEF,
  parameter int DELAY         = DELAY_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic sig_i,
  output logic sig_o
);

  localparam int DW = cntWidth(DEBOUNCE_TIME);
  localparam int LW = cntWidth(DELAY);
  localparam logic [DW-1:0] DEB_TARGET = DW'(DEBOUNCE_TIME);
  localparam logic [LW-1:0] LOCK_LOAD  = LW'(DELAY);

  logic          level_q, level_d;
  logic [DW-1:0] dbCnt_q, dbCnt_d, dbInc;
  logic [LW-1:0] lock_q, lock_d;
  logic          out_q, out_d;
  outAction_e    action;

  // The debounce counter restarts whenever the raw input agrees with the accepted level.
  always_comb begin
    level_d = level_q;
    dbCnt_d = '0;
    dbInc   = dbCnt_q + DW'(1);
    if (sig_i != level_q) begin
      if (dbInc == DEB_TARGET) begin
        level_d = sig_i;
      end else begin
        dbCnt_d = dbInc;
      end
    end
  end

  always_comb begin
    if (!level_d) begin
      action = OUT_CLEAR;
    end else if (out_q) begin
      action = OUT_HOLD;
    end else if (lock_q == '0) begin
      action = OUT_RISE;
    end else begin
      action = OUT_BLOCKED;
    end
  end

  // A fall is never delayed by lockout; only a new rise waits for the counter to drain.
  always_comb begin
    out_d  = out_q;
    lock_d = (lock_q != '0) ? lock_q - LW'(1) : lock_q;
    unique case (action)
      OUT_CLEAR:   out_d = 1'b0;
      OUT_RISE: begin
        out_d  = 1'b1;
        lock_d = LOCK_LOAD;
      end
      OUT_BLOCKED: out_d = 1'b0;
      OUT_HOLD:    out_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      level_q <= 1'b0;
      dbCnt_q <= '0;
      lock_q  <= '0;
      out_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      dbCnt_q <= dbCnt_d;
      lock_q  <= lock_d;
      out_q   <= out_d;
    end
  end

  assign sig_o = out_q;

endmodule

// File: rtl/regularization_4bit_sync.sv
// Four independent debounce-and-lockout channels for the jump-set condition flags;
// bit k of the input and output belongs to channel k.
module regularization_4bit_sync
  import regularization_4bit_sync_pkg::*;
#(
  parameter int DEBOUNCE_TIME = DEBOUNCE_TIME_DEF,
  parameter int DELAY         = DELAY_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [NUM_CHANNELS-1:0] i_signal,
  output logic [NUM_CHANNELS-1:0] o_signal
);

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : gChannel
    regularization_channel #(
      .DEBOUNCE_TIME(DEBOUNCE_TIME),
      .DELAY        (DELAY)
    ) uChannel (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .sig_i  (i_signal[k]),
      .sig_o  (o_signal[k])
    );
  end

endmodule

// File: tb/tb_regularization_4bit_sync.sv
// Directed bench: the stimulus pushes hand-derived per-edge expectations into a queue
// and an independent monitor pops one entry per clock edge and compares.
module tb_regularization_4bit_sync;

  logic       i_clk;
  logic       i_reset;
  logic [3:0] i_signal;
  logic [3:0] o_signal;
  logic [3:0] oSignalZ;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] exp;
    logic [3:0] expZ;
    logic       checkZ;
    string      name;
  } expect_t;

  expect_t expQ[$];

  regularization_4bit_sync #(.DEBOUNCE_TIME(2), .DELAY(500)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_signal(i_signal),
    .o_signal(o_signal)
  );

  regularization_4bit_sync #(.DEBOUNCE_TIME(2), .DELAY(0)) dutZ (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_signal(i_signal),
    .o_signal(oSignalZ)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Each call drives one input pattern for a number of edges; exp/expZ are the outputs after each edge.
  task automatic applyStimulus(input logic rst, input logic [3:0] sig, input int cycles,
                               input logic [3:0] exp, input logic [3:0] expZ,
                               input logic checkZ, input string name);
    expect_t e;
    for (int i = 0; i < cycles; i++) begin
      @(negedge i_clk);
      i_reset  = rst;
      i_signal = sig;
      e.exp    = exp;
      e.expZ   = expZ;
      e.checkZ = checkZ;
      e.name   = name;
      expQ.push_back(e);
    end
  endtask

  initial begin : monitor
    expect_t e;
    forever begin
      @(posedge i_clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e.name, o_signal, e.exp);
        if (e.checkZ) checkOutput({e.name, "_delay0"}, oSignalZ, e.expZ);
      end
    end
  end

  initial begin : stimulus
    i_reset  = 1'b1;
    i_signal = 4'h0;

    // Reset with all inputs high, then release and expect the rise one edge later.
    applyStimulus(1'b1, 4'hF, 2, 4'h0, 4'h0, 1'b1, "reset_hold");
    applyStimulus(1'b0, 4'hF, 1, 4'h0, 4'h0, 1'b1, "release_first_edge");
    applyStimulus(1'b0, 4'hF, 1, 4'hF, 4'hF, 1'b1, "release_rise");
    applyStimulus(1'b0, 4'hF, 3, 4'hF, 4'hF, 1'b1, "release_hold");

    // Glitch rejection on bit 0, then a two-cycle pulse passed through with a one-edge delay.
    applyStimulus(1'b1, 4'h0, 2, 4'h0, 4'h0, 1'b1, "reset");
    applyStimulus(1'b0, 4'h1, 1, 4'h0, 4'h0, 1'b1, "glitch1_high");
    applyStimulus(1'b0, 4'h0, 3, 4'h0, 4'h0, 1'b1, "glitch1_after");
    applyStimulus(1'b0, 4'h1, 1, 4'h0, 4'h0, 1'b1, "pulse2_first");
    applyStimulus(1'b0, 4'h1, 1, 4'h1, 4'h1, 1'b1, "pulse2_rise");
    applyStimulus(1'b0, 4'h0, 1, 4'h1, 4'h1, 1'b1, "pulse2_tail");
    applyStimulus(1'b0, 4'h0, 3, 4'h0, 4'h0, 1'b1, "pulse2_fall");

    // Lockout on bit 1: rise at E, drop 5 cycles, reassert; main DUT re-rises at E+501, DELAY=0 at E+7.
    applyStimulus(1'b1, 4'h0, 2, 4'h0, 4'h0, 1'b1, "reset");
    applyStimulus(1'b0, 4'h2, 1, 4'h0, 4'h0, 1'b1, "lock_first");
    applyStimulus(1'b0, 4'h2, 1, 4'h2, 4'h2, 1'b1, "lock_rise");
    applyStimulus(1'b0, 4'h0, 1, 4'h2, 4'h2, 1'b1, "lock_drop_first");
    applyStimulus(1'b0, 4'h0, 4, 4'h0, 4'h0, 1'b1, "lock_dropped");
    applyStimulus(1'b0, 4'h2, 1, 4'h0, 4'h0, 1'b1, "lock_reassert_first");
    applyStimulus(1'b0, 4'h2, 1, 4'h0, 4'h2, 1'b1, "lock_blocked_start");
    applyStimulus(1'b0, 4'h2, 493, 4'h0, 4'h2, 1'b1, "lock_blocked");
    applyStimulus(1'b0, 4'h2, 1, 4'h2, 4'h2, 1'b1, "lock_rerise");
    applyStimulus(1'b0, 4'h2, 3, 4'h2, 4'h2, 1'b1, "lock_rerise_hold");

    // Fall during lockout on bit 2 is not delayed.
    applyStimulus(1'b1, 4'h0, 2, 4'h0, 4'h0, 1'b1, "reset");
    applyStimulus(1'b0, 4'h4, 1, 4'h0, 4'h0, 1'b1, "fall_first");
    applyStimulus(1'b0, 4'h4, 3, 4'h4, 4'h4, 1'b1, "fall_high");
    applyStimulus(1'b0, 4'h0, 1, 4'h4, 4'h4, 1'b1, "fall_debounce");
    applyStimulus(1'b0, 4'h0, 3, 4'h0, 4'h0, 1'b1, "fall_low");

    // Independence: bit 0 rises at E0, bit 3 at E0+100; both re-rise 501 edges after their own rise.
    applyStimulus(1'b1, 4'h0, 2, 4'h0, 4'h0, 1'b1, "reset");
    applyStimulus(1'b0, 4'h1, 1, 4'h0, 4'h0, 1'b0, "ind_first");
    applyStimulus(1'b0, 4'h1, 1, 4'h1, 4'h0, 1'b0, "ind_rise0");
    applyStimulus(1'b0, 4'h0, 1, 4'h1, 4'h0, 1'b0, "ind_drop0_first");
    applyStimulus(1'b0, 4'h0, 97, 4'h0, 4'h0, 1'b0, "ind_idle");
    applyStimulus(1'b0, 4'h8, 1, 4'h0, 4'h0, 1'b0, "ind_first3");
    applyStimulus(1'b0, 4'h8, 1, 4'h8, 4'h0, 1'b0, "ind_rise3");
    applyStimulus(1'b0, 4'h0, 1, 4'h8, 4'h0, 1'b0, "ind_drop3_first");
    applyStimulus(1'b0, 4'h0, 2, 4'h0, 4'h0, 1'b0, "ind_drop3");
    applyStimulus(1'b0, 4'h9, 397, 4'h0, 4'h0, 1'b0, "ind_both_blocked");
    applyStimulus(1'b0, 4'h9, 100, 4'h1, 4'h0, 1'b0, "ind_bit0_only");
    applyStimulus(1'b0, 4'h9, 3, 4'h9, 4'h0, 1'b0, "ind_both_high");

    // Reset 200 edges after a rise clears lockout, so the rise follows release normally.
    applyStimulus(1'b1, 4'h0, 2, 4'h0, 4'h0, 1'b1, "reset");
    applyStimulus(1'b0, 4'h1, 1, 4'h0, 4'h0, 1'b1, "mid_first");
    applyStimulus(1'b0, 4'h1, 200, 4'h1, 4'h1, 1'b1, "mid_high");
    applyStimulus(1'b1, 4'h1, 1, 4'h0, 4'h0, 1'b1, "mid_reset");
    applyStimulus(1'b0, 4'h1, 1, 4'h0, 4'h0, 1'b1, "mid_release_first");
    applyStimulus(1'b0, 4'h1, 3, 4'h1, 4'h1, 1'b1, "mid_release_rise");

    repeat (3) @(negedge i_clk);
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
